// File: rtl/uart_rx_cmd_pkg.sv
// Shared definitions for the host command link: command bytes, drive
// direction encodings, receiver FSM states and the command decoder.
package uart_rx_cmd_pkg;

    // ASCII command bytes accepted from the host
    localparam logic [7:0] CMD_FWD   = 8'h46;  // 'F'
    localparam logic [7:0] CMD_REV   = 8'h42;  // 'B'
    localparam logic [7:0] CMD_LEFT  = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RIGHT = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STOP  = 8'h53;  // 'S'

    // Drive direction word: bit0 fwd, bit1 rev, bit2 left, bit3 right
    localparam logic [3:0] DIR_FWD   = 4'b0001;
    localparam logic [3:0] DIR_REV   = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;
    localparam logic [3:0] DIR_STOP  = 4'b0000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] dir;
    } cmd_dec_t;

    // Map a received byte onto a direction word; legal=0 for unknown bytes
    function automatic cmd_dec_t decode_cmd(input logic [7:0] value);
        cmd_dec_t dec;
        dec.legal = 1'b1;
        dec.dir   = DIR_STOP;
        case (value)
            CMD_FWD:   dec.dir = DIR_FWD;
            CMD_REV:   dec.dir = DIR_REV;
            CMD_LEFT:  dec.dir = DIR_LEFT;
            CMD_RIGHT: dec.dir = DIR_RIGHT;
            CMD_STOP:  dec.dir = DIR_STOP;
            default:   dec.legal = 1'b0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/uart_rx_cmd_if.sv
// Command-link bundle: serial line in, received byte and decoded drive
// command out. master = line/host side, slave = receiver.
interface uart_rx_cmd_if;
    logic       rxData;
    logic [7:0] rxByte;
    logic       rxValid;
    logic       frameErr;
    logic [3:0] dirControl;
    logic       cmdValid;
    logic       cmdErr;

    modport master (
        output rxData,
        input  rxByte, rxValid, frameErr, dirControl, cmdValid, cmdErr
    );

    modport slave (
        input  rxData,
        output rxByte, rxValid, frameErr, dirControl, cmdValid, cmdErr
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receive core: input synchronizer, bit-timing FSM and shift register.
// byte_done/shift_data expose the stop-bit decision one edge early so the
// top level can register its decode on the same edge as rx_valid.
module uart_rx_core
    import uart_rx_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2604,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       byte_done,
    output logic [7:0] shift_data
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_prev;

    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          done, ferr;

    assign rxs        = sync_q[SYNC_STAGES-1];
    assign byte_done  = done;
    assign shift_data = shift;

    // Synchronizer chain and previous-sample register, idle-high on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q   <= '1;
            rxs_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rx_line};
            rxs_prev <= rxs;
        end
    end

    // Frame FSM next-state: half-bit start check, then mid-bit samples
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        done    = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_prev && !rxs) begin
                    state_n = START;
                    cnt_n   = '0;
                    bit_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    // still high at mid start bit: treat as a glitch
                    state_n = rxs ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rxs, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rxs) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                // a held-low break must not look like a new start edge
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Frame FSM state, datapath and registered output pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shift     <= shift_n;
            rx_valid  <= done;
            frame_err <= ferr;
            if (done) rx_byte <= shift;
        end
    end

endmodule

// File: rtl/uart_rx_cmd.sv
// Host command receiver: 8N1 core plus ASCII drive-command decoder and
// held direction register feeding the H-bridge control.
module uart_rx_cmd
    import uart_rx_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2604,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_cmd_if.slave  bus
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       byte_done;
    logic [7:0] shift_data;
    cmd_dec_t   dec;
    logic [3:0] dir;
    logic       cmd_valid;
    logic       cmd_err;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .rx_line    (bus.rxData),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .byte_done  (byte_done),
        .shift_data (shift_data)
    );

    assign dec = decode_cmd(shift_data);

    // Decode on the same edge that publishes the byte; reset stops motors
    always_ff @(posedge clk) begin
        if (!rst) begin
            dir       <= DIR_STOP;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_valid <= byte_done && dec.legal;
            cmd_err   <= byte_done && !dec.legal;
            if (byte_done && dec.legal) dir <= dec.dir;
        end
    end

    assign bus.rxByte     = rx_byte;
    assign bus.rxValid    = rx_valid;
    assign bus.frameErr   = frame_err;
    assign bus.dirControl = dir;
    assign bus.cmdValid   = cmd_valid;
    assign bus.cmdErr     = cmd_err;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Bench for uart_rx_cmd: directed command-link scenarios followed by random
// frames, all checked against a frame-level model of the receiver.
module tb_uart_rx_cmd;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_cmd_if bus();

    uart_rx_cmd #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // pulse monitor
    int         n_rxv = 0, n_fe = 0, n_cv = 0, n_ce = 0, n_viol = 0;
    logic [7:0] cap_byte = 8'h00;
    logic [3:0] cap_dir  = 4'h0;

    always @(negedge clk) begin
        if (bus.rxValid) begin
            n_rxv    <= n_rxv + 1;
            cap_byte <= bus.rxByte;
            cap_dir  <= bus.dirControl;
        end
        if (bus.frameErr) n_fe <= n_fe + 1;
        if (bus.cmdValid) n_cv <= n_cv + 1;
        if (bus.cmdErr)   n_ce <= n_ce + 1;
        if ((bus.rxValid && bus.frameErr) || (bus.cmdValid && bus.cmdErr) ||
            ((bus.cmdValid || bus.cmdErr) && !bus.rxValid))
            n_viol <= n_viol + 1;
    end

    // frame-level model state
    logic [7:0] m_byte = 8'h00;
    logic [3:0] m_dir  = 4'h0;

    function automatic bit ref_cmd(input logic [7:0] b, output logic [3:0] d);
        d = 4'b0000;
        case (b)
            8'h46: d = 4'b0001;
            8'h42: d = 4'b0010;
            8'h4C: d = 4'b0100;
            8'h52: d = 4'b1000;
            8'h53: d = 4'b0000;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.rxData = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // drive the first nbits of start/data/stop, LSB first; line left at last bit
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.rxData = fr[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input logic stop_ok,
                            input int low_tail);
        int s_rxv, s_fe, s_cv, s_ce;
        bit legal;
        logic [3:0] d;
        s_rxv = n_rxv; s_fe = n_fe; s_cv = n_cv; s_ce = n_ce;
        send_frame(b, stop_ok, 10);
        repeat (low_tail) @(negedge clk);
        bus.rxData = 1'b1;
        legal = ref_cmd(b, d);
        if (stop_ok) begin
            m_byte = b;
            if (legal) m_dir = d;
        end
        check({tag, ".rxValid"},  n_rxv - s_rxv, 32'(stop_ok));
        check({tag, ".frameErr"}, n_fe - s_fe,   32'(!stop_ok));
        check({tag, ".cmdValid"}, n_cv - s_cv,   32'(stop_ok && legal));
        check({tag, ".cmdErr"},   n_ce - s_ce,   32'(stop_ok && !legal));
        check({tag, ".rxByte"},   bus.rxByte,     m_byte);
        check({tag, ".dir"},      bus.dirControl, m_dir);
        if (stop_ok) begin
            check({tag, ".byteAtPulse"}, cap_byte, b);
            check({tag, ".dirAtPulse"},  cap_dir,  m_dir);
        end
    endtask

    logic [7:0] cmds [5] = '{8'h46, 8'h42, 8'h4C, 8'h52, 8'h53};

    initial begin
        int s_rxv, s_fe, s_cv, s_ce;
        logic [7:0] rb;
        logic       ok;

        bus.rxData = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset.rxByte",   bus.rxByte,     8'h00);
        check("reset.dir",      bus.dirControl, 4'h0);
        check("reset.rxValid",  bus.rxValid,    1'b0);
        check("reset.frameErr", bus.frameErr,   1'b0);
        check("reset.cmdValid", bus.cmdValid,   1'b0);
        check("reset.cmdErr",   bus.cmdErr,     1'b0);
        rst = 1'b1;
        idle(10);

        // forward command
        do_frame("F", 8'h46, 1'b1, 0);
        idle(7);

        // back-to-back, no idle gap
        do_frame("L", 8'h4C, 1'b1, 0);
        do_frame("S", 8'h53, 1'b1, 0);
        idle(5);

        // illegal byte after a legal one keeps the direction
        do_frame("R", 8'h52, 1'b1, 0);
        do_frame("A", 8'h41, 1'b1, 0);
        idle(5);

        // framing error followed by a break, then recovery
        do_frame("ferr", 8'h52, 1'b0, 40);
        idle(6);
        do_frame("B_after_ferr", 8'h42, 1'b1, 0);
        idle(5);

        // short glitch shorter than half a bit
        s_rxv = n_rxv; s_fe = n_fe;
        bus.rxData = 1'b0;
        repeat (4) @(negedge clk);
        idle(24);
        check("glitch.rxValid",  n_rxv - s_rxv, 0);
        check("glitch.frameErr", n_fe - s_fe,   0);
        do_frame("F_after_glitch", 8'h46, 1'b1, 0);
        idle(5);

        // reset in the middle of a frame
        do_frame("F_pre_rst", 8'h46, 1'b1, 0);
        s_rxv = n_rxv; s_fe = n_fe; s_cv = n_cv; s_ce = n_ce;
        send_frame(8'h4C, 1'b1, 5);
        bus.rxData = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        m_byte = 8'h00;
        m_dir  = 4'h0;
        check("midrst.dir",      bus.dirControl, 4'h0);
        check("midrst.rxByte",   bus.rxByte,     8'h00);
        idle(200);
        check("midrst.rxValid",  n_rxv - s_rxv, 0);
        check("midrst.frameErr", n_fe - s_fe,   0);
        check("midrst.cmdValid", n_cv - s_cv,   0);
        check("midrst.cmdErr",   n_ce - s_ce,   0);
        do_frame("R_after_rst", 8'h52, 1'b1, 0);
        idle(5);

        // random frames: mix of commands and arbitrary bytes, some bad stops
        for (int i = 0; i < 24; i++) begin
            rb = ($urandom_range(0, 1) == 0) ? cmds[$urandom_range(0, 4)] : 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            if (ok) begin
                do_frame("rand", rb, 1'b1, 0);
                idle($urandom_range(0, 12));
            end else begin
                do_frame("rand_ferr", rb, 1'b0, $urandom_range(0, 20));
                idle($urandom_range(4, 10));
            end
        end

        check("exclusion", n_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cmd.md
Name: uart_rx_cmd

Overview:
8N1 UART receiver for the host command link, the receive-side counterpart to the existing UART status transmitter (txData). It samples rxData, assembles bytes, flags framing errors, and decodes single-byte ASCII drive commands into a held direction-control word. It sits beside the UART transmitter and feeds the drive/H-bridge control logic.

Parameters:
CLKS_PER_BIT, 2604, clk cycles per bit (25 MHz / 9600 baud); legal range >= 8.
SYNC_STAGES, 2, flip-flops in the rxData input synchronizer; legal range >= 2.

Ports:
clk  input  1  system clock, 25 MHz; all logic on rising edge.
rst  input  1  synchronous, active-low reset (rst=0 resets on the next clk edge).
rxData  input  1  asynchronous serial input; idle high.
rxByte  output  8  last correctly framed byte; held until the next good byte.
rxValid  output  1  one-cycle pulse when rxByte updates.
frameErr  output  1  one-cycle pulse when the stop bit is sampled low.
dirControl  output  4  decoded drive command, held: bit0 forward, bit1 reverse, bit2 left, bit3 right.
cmdValid  output  1  one-cycle pulse when dirControl is (re)loaded by a legal command.
cmdErr  output  1  one-cycle pulse when a good byte is not a legal command.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; counters=0; rxByte=8'h00; dirControl=4'b0000; all pulses=0; synchronizer flops=1 (idle).
- Input: rxData passes SYNC_STAGES flops; only the final stage (rxs) is used; rxs-prev is registered for edge detection.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: a falling edge on rxs (prev=1, now=0) -> START, bit counter cleared.
- START: count CLKS_PER_BIT/2 (integer division) cycles, then sample rxs. Low -> DATA with counter reset. High -> glitch; return to IDLE with no pulse.
- DATA: sample rxs every CLKS_PER_BIT cycles (mid-bit), 8 samples, shifted in LSB first. After the 8th sample -> STOP.
- STOP: sample rxs after CLKS_PER_BIT cycles.
  - High: rxByte<=shift register, rxValid=1 for one cycle, -> IDLE.
  - Low: frameErr=1 for one cycle, rxByte unchanged, no decode, -> WAIT_IDLE.
- WAIT_IDLE: remain until rxs=1, then -> IDLE. This prevents a break condition from retriggering.
- Latency: rxValid asserts on the clk edge after the stop-bit mid-sample. That is roughly 9.5 bit times plus SYNC_STAGES+1 cycles after the start-bit falling edge.
- Command decode runs in the same cycle rxValid asserts, from the new byte:
  - 0x46 'F' -> 4'b0001
  - 0x42 'B' -> 4'b0010
  - 0x4C 'L' -> 4'b0100
  - 0x52 'R' -> 4'b1000
  - 0x53 'S' -> 4'b0000
  - Any legal command loads dirControl and pulses cmdValid together with rxValid.
  - Any other byte: dirControl held, cmdErr pulses together with rxValid.
- Mutual exclusion: rxValid and frameErr never assert in the same cycle; cmdValid and cmdErr never assert in the same cycle.
- Back-to-back frames: a start edge arriving immediately after the stop-bit sample (IDLE entered that cycle) must be accepted; no dead time beyond one cycle.
- Reset mid-frame: the partial byte is discarded, no pulses, and dirControl=0 (motors stop).
- Counter width: $clog2(CLKS_PER_BIT) bits. The bit index is 3 bits and wraps only via the state change.

Decomposition:
- Shared package holds:
  - command byte constants CMD_FWD/CMD_REV/CMD_LEFT/CMD_RIGHT/CMD_STOP;
  - dirControl encodings DIR_FWD=4'b0001, DIR_REV=4'b0010, DIR_LEFT=4'b0100, DIR_RIGHT=4'b1000, DIR_STOP=4'b0000;
  - the FSM state encoding.
- The same package is used by the transmitter and the drive logic.
- One sub-module: uart_rx_core (synchronizer + FSM + shift register; outputs rxByte/rxValid/frameErr). The top level adds the command decoder and the dirControl register.

Test Plan:
- CLKS_PER_BIT=16. Send 0x46 'F' as 8N1 -> rxByte=0x46; rxValid, cmdValid one cycle each; dirControl=4'b0001; cmdErr=0.
- Send 'L' then 'S' back-to-back with no idle gap -> two rxValid pulses; dirControl 4'b0100 then 4'b0000; no frameErr.
- Send 0x41 'A' after 'R' -> rxValid=1, cmdErr=1, rxByte=0x41, dirControl stays 4'b1000.
- Send 0x52 with stop bit driven low, then hold the line low 40 cycles -> frameErr one pulse; rxByte and dirControl unchanged; no rxValid. After the line returns high, a following 'B' decodes to 4'b0010.
- Pulse rxData low for 4 cycles (< half bit) -> returns to IDLE; no rxValid/frameErr. The next valid frame is received correctly.
- Send 'F', then assert rst=0 for one cycle mid-way through the next frame -> dirControl=0, rxByte=0x00, no pulses. The following frame is received normally.
